// File: rtl/cache_axi_read_arbiter.sv
// Shares one AXI4 read master between the instruction cache (port 0) and the
// data cache (port 1): round-robin burst grant, registered AR, routed R beats.
module cache_axi_read_arbiter #(
  parameter int         M_AXI_ADDR_WIDTH = 32,
  parameter int         M_AXI_DATA_WIDTH = 32,
  parameter logic [7:0] P0_BURST_LEN     = 8'd7,
  parameter logic [7:0] P1_BURST_LEN     = 8'd7,
  parameter logic [2:0] M_AXI_BURST_SIZE = 3'd2
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,

  input  logic [M_AXI_ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic                        S0_ARVALID,
  output logic                        S0_ARREADY,
  output logic [M_AXI_DATA_WIDTH-1:0] S0_RDATA,
  output logic [1:0]                  S0_RRESP,
  output logic                        S0_RVALID,
  output logic                        S0_RLAST,
  input  logic                        S0_RREADY,

  input  logic [M_AXI_ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic                        S1_ARVALID,
  output logic                        S1_ARREADY,
  output logic [M_AXI_DATA_WIDTH-1:0] S1_RDATA,
  output logic [1:0]                  S1_RRESP,
  output logic                        S1_RVALID,
  output logic                        S1_RLAST,
  input  logic                        S1_RREADY,

  output logic [M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic [1:0]                  M_AXI_RRESP,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,

  output logic                        len_err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t                      state_q;
  state_t                      state_d;
  logic                        last_grant_q;
  logic                        owner_q;
  logic [M_AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]                  ar_len_q;
  logic                        ar_valid_q;
  logic [7:0]                  beat_cnt_q;
  logic                        len_err_q;

  logic                        winner;
  logic                        grant_fire;
  logic                        beat_xfer;
  logic                        s0_arready;
  logic                        s1_arready;
  logic                        s0_rvalid;
  logic                        s1_rvalid;
  logic                        m_rready;

  // On a tie the port that did not win last time is favoured.
  assign winner = (S0_ARVALID && S1_ARVALID) ? ~last_grant_q : S1_ARVALID;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_rready   = 1'b0;
    grant_fire = 1'b0;
    beat_xfer  = 1'b0;
    case (state_q)
      IDLE: begin
        // Reset gating keeps ARREADY low while ARESETN is held asserted.
        if (ARESETN && (S0_ARVALID || S1_ARVALID)) begin
          s0_arready = ~winner;
          s1_arready = winner;
          grant_fire = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = DATA;
        end
      end
      DATA: begin
        m_rready  = owner_q ? S1_RREADY : S0_RREADY;
        s0_rvalid = M_AXI_RVALID && !owner_q;
        s1_rvalid = M_AXI_RVALID && owner_q;
        beat_xfer = M_AXI_RVALID && m_rready;
        if (beat_xfer && M_AXI_RLAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A beat is in error when RLAST disagrees with whether the count says last.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ar_addr_q    <= '0;
      ar_len_q     <= 8'd0;
      ar_valid_q   <= 1'b0;
      beat_cnt_q   <= 8'd0;
      len_err_q    <= 1'b0;
    end else begin
      if (grant_fire) begin
        ar_addr_q    <= winner ? S1_ARADDR : S0_ARADDR;
        ar_len_q     <= winner ? P1_BURST_LEN : P0_BURST_LEN;
        owner_q      <= winner;
        last_grant_q <= winner;
        beat_cnt_q   <= 8'd0;
        ar_valid_q   <= 1'b1;
      end
      if (state_q == ADDR && M_AXI_ARREADY) begin
        ar_valid_q <= 1'b0;
      end
      if (beat_xfer) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
        if (M_AXI_RLAST != (beat_cnt_q == ar_len_q)) begin
          len_err_q <= 1'b1;
        end
      end
    end
  end

  assign S0_ARREADY    = s0_arready;
  assign S1_ARREADY    = s1_arready;
  assign S0_RVALID     = s0_rvalid;
  assign S1_RVALID     = s1_rvalid;
  assign M_AXI_RREADY  = m_rready;

  assign S0_RDATA      = M_AXI_RDATA;
  assign S1_RDATA      = M_AXI_RDATA;
  assign S0_RRESP      = M_AXI_RRESP;
  assign S1_RRESP      = M_AXI_RRESP;
  assign S0_RLAST      = M_AXI_RLAST;
  assign S1_RLAST      = M_AXI_RLAST;

  assign M_AXI_ARADDR  = ar_addr_q;
  assign M_AXI_ARLEN   = ar_len_q;
  assign M_AXI_ARVALID = ar_valid_q;
  assign M_AXI_ARSIZE  = M_AXI_BURST_SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Directed bench for cache_axi_read_arbiter: grant order, AR timing, beat
// routing, RREADY back-pressure, burst-length errors and mid-burst reset.
module tb_cache_axi_read_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] S0_ARADDR, S1_ARADDR;
  logic        S0_ARVALID, S1_ARVALID;
  logic        S0_ARREADY, S1_ARREADY;
  logic [31:0] S0_RDATA, S1_RDATA;
  logic [1:0]  S0_RRESP, S1_RRESP;
  logic        S0_RVALID, S1_RVALID;
  logic        S0_RLAST, S1_RLAST;
  logic        S0_RREADY, S1_RREADY;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARVALID, M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;
  logic        len_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int burst_tag    = 0;

  cache_axi_read_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_ARADDR(S0_ARADDR), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RRESP(S0_RRESP), .S0_RVALID(S0_RVALID),
    .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RRESP(S1_RRESP), .S1_RVALID(S1_RVALID),
    .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY),
    .len_err(len_err)
  );

  always #5 ACLK = ~ACLK;

  task automatic do_reset();
    ARESETN = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
  endtask

  // Entered at posedge+1 with the request(s) already driven; leaves the DUT in DATA.
  task automatic grant_and_addr(input int port, input logic [31:0] addr,
                                input int ar_delay, input logic reraise,
                                input logic [31:0] re_addr);
    #1;
    tests_run++;
    if (S0_ARREADY !== 1'(port == 0) || S1_ARREADY !== 1'(port == 1)) begin
      tests_failed++;
      $display("[TB] FAIL grant: got arready s0=%b s1=%b, expected port %0d", S0_ARREADY, S1_ARREADY, port);
    end
    tests_run++;
    if (M_AXI_ARVALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL arvalid_early: got %b expected 0", M_AXI_ARVALID);
    end
    @(posedge ACLK); #1;
    if (port == 0) S0_ARVALID = 1'b0; else S1_ARVALID = 1'b0;
    for (int c = 0; c < ar_delay; c++) begin
      if (reraise && c == 1) begin
        S0_ARADDR  = re_addr;
        S0_ARVALID = 1'b1;
      end
      #1;
      tests_run++;
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== addr || M_AXI_ARLEN !== 8'd7 ||
          S0_ARREADY !== 1'b0 || S1_ARREADY !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ar_wait%0d: got v=%b a=%h l=%0d rdy=%b%b expected v=1 a=%h l=7 rdy=00",
                 c, M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, S0_ARREADY, S1_ARREADY, addr);
      end
      @(posedge ACLK); #1;
    end
    M_AXI_ARREADY = 1'b1;
    #1;
    tests_run++;
    if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== addr || M_AXI_ARLEN !== 8'd7 ||
        M_AXI_ARSIZE !== 3'd2 || M_AXI_ARBURST !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL ar_issue: got v=%b a=%h l=%0d s=%0d b=%0d expected v=1 a=%h l=7 s=2 b=1",
               M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, addr);
    end
    @(posedge ACLK); #1;
    M_AXI_ARREADY = 1'b0;
    tests_run++;
    if (M_AXI_ARVALID !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ar_drop: got %b expected 0", M_AXI_ARVALID);
    end
  endtask

  // Plays nbeats slave beats to the owning port, optionally stalling its RREADY.
  task automatic run_beats(input int port, input int nbeats, input int last_idx,
                           input int stall_beat, input int stall_cycles);
    logic [31:0] exp_data;
    logic        own_v, other_v;
    for (int i = 0; i < nbeats; i++) begin
      exp_data     = {8'hD0 + 8'(port), 8'(burst_tag), 16'(i)};
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = exp_data;
      M_AXI_RRESP  = 2'(i);
      M_AXI_RLAST  = (i == last_idx);
      for (int s = 0; s < ((i == stall_beat) ? stall_cycles : 0); s++) begin
        if (port == 0) S0_RREADY = 1'b0; else S1_RREADY = 1'b0;
        #1;
        own_v = (port == 0) ? S0_RVALID : S1_RVALID;
        tests_run++;
        if (M_AXI_RREADY !== 1'b0 || own_v !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL stall%0d: got rready=%b rvalid=%b expected rready=0 rvalid=1", s, M_AXI_RREADY, own_v);
        end
        @(posedge ACLK); #1;
      end
      S0_RREADY = 1'b1;
      S1_RREADY = 1'b1;
      #1;
      own_v   = (port == 0) ? S0_RVALID : S1_RVALID;
      other_v = (port == 0) ? S1_RVALID : S0_RVALID;
      tests_run++;
      if (own_v !== 1'b1 || other_v !== 1'b0 || M_AXI_RREADY !== 1'b1 ||
          ((port == 0) ? S0_RDATA : S1_RDATA) !== exp_data ||
          ((port == 0) ? S0_RLAST : S1_RLAST) !== 1'(i == last_idx) ||
          ((port == 0) ? S0_RRESP : S1_RRESP) !== 2'(i)) begin
        tests_failed++;
        $display("[TB] FAIL beat%0d_p%0d: got v=%b ov=%b rr=%b d=%h expected v=1 ov=0 rr=1 d=%h",
                 i, port, own_v, other_v, M_AXI_RREADY,
                 (port == 0) ? S0_RDATA : S1_RDATA, exp_data);
      end
      @(posedge ACLK); #1;
    end
    M_AXI_RVALID = 1'b0;
    M_AXI_RLAST  = 1'b0;
    burst_tag++;
  endtask

  task automatic test_reset();
    ARESETN      = 1'b0;
    S0_ARVALID   = 1'b1;
    S1_ARVALID   = 1'b1;
    S0_ARADDR    = 32'h1234_0000;
    S1_ARADDR    = 32'h5678_0000;
    S0_RREADY    = 1'b1;
    S1_RREADY    = 1'b1;
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 32'h0;
    M_AXI_RRESP  = 2'b00;
    M_AXI_RLAST  = 1'b0;
    M_AXI_ARREADY = 1'b0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    tests_run++;
    if (S0_ARREADY !== 1'b0 || S1_ARREADY !== 1'b0 || S0_RVALID !== 1'b0 ||
        S1_RVALID !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshakes: got arr=%b%b rv=%b%b rr=%b expected all 0",
               S0_ARREADY, S1_ARREADY, S0_RVALID, S1_RVALID, M_AXI_RREADY);
    end
    tests_run++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_ARADDR !== 32'h0 || M_AXI_ARLEN !== 8'd0 || len_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got v=%b a=%h l=%0d e=%b expected 0", M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, len_err);
    end
    S0_ARVALID   = 1'b0;
    S1_ARVALID   = 1'b0;
    M_AXI_RVALID = 1'b0;
    ARESETN      = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_single_burst();
    S0_ARADDR  = 32'h1FC0_0000;
    S0_ARVALID = 1'b1;
    grant_and_addr(0, 32'h1FC0_0000, 0, 1'b0, 32'h0);
    tests_run++;
    if (S0_ARREADY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL arready_pulse: got %b expected 0", S0_ARREADY);
    end
    run_beats(0, 8, 7, -1, 0);
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_len_err: got %b expected 0", len_err);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    S0_ARADDR  = 32'h0000_0100;
    S1_ARADDR  = 32'h0000_0200;
    S0_ARVALID = 1'b1;
    S1_ARVALID = 1'b1;
    grant_and_addr(0, 32'h0000_0100, 0, 1'b0, 32'h0);
    run_beats(0, 8, 7, -1, 0);
    grant_and_addr(1, 32'h0000_0200, 0, 1'b0, 32'h0);
    run_beats(1, 8, 7, -1, 0);
    S0_ARVALID = 1'b1;
    S1_ARVALID = 1'b1;
    grant_and_addr(0, 32'h0000_0100, 0, 1'b0, 32'h0);
    S1_ARVALID = 1'b0;
    run_beats(0, 8, 7, -1, 0);
  endtask

  task automatic test_rready_stall();
    S1_ARADDR  = 32'h0000_4400;
    S1_ARVALID = 1'b1;
    grant_and_addr(1, 32'h0000_4400, 0, 1'b0, 32'h0);
    run_beats(1, 8, 7, 2, 3);
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_len_err: got %b expected 0", len_err);
    end
  endtask

  task automatic test_len_err();
    S0_ARADDR  = 32'h0000_5500;
    S0_ARVALID = 1'b1;
    grant_and_addr(0, 32'h0000_5500, 0, 1'b0, 32'h0);
    run_beats(0, 4, 3, -1, 0);
    tests_run++;
    if (len_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL short_burst_err: got %b expected 1", len_err);
    end
    S1_ARADDR  = 32'h0000_6600;
    S1_ARVALID = 1'b1;
    grant_and_addr(1, 32'h0000_6600, 0, 1'b0, 32'h0);
    run_beats(1, 8, 7, -1, 0);
    tests_run++;
    if (len_err !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL err_sticky: got %b expected 1", len_err);
    end
  endtask

  task automatic test_ar_delay();
    S0_ARADDR  = 32'h0000_7700;
    S0_ARVALID = 1'b1;
    grant_and_addr(0, 32'h0000_7700, 5, 1'b1, 32'h0000_8800);
    run_beats(0, 8, 7, -1, 0);
    grant_and_addr(0, 32'h0000_8800, 0, 1'b0, 32'h0);
    run_beats(0, 8, 7, -1, 0);
  endtask

  task automatic test_reset_mid_burst();
    S0_ARADDR  = 32'h0000_9900;
    S0_ARVALID = 1'b1;
    grant_and_addr(0, 32'h0000_9900, 0, 1'b0, 32'h0);
    run_beats(0, 2, 99, -1, 0);
    M_AXI_RVALID = 1'b1;
    M_AXI_RDATA  = 32'hBAD0_0003;
    S1_ARADDR    = 32'h0000_AA00;
    S1_ARVALID   = 1'b1;
    ARESETN      = 1'b0;
    #1;
    tests_run++;
    if (S0_RVALID !== 1'b0 || M_AXI_RREADY !== 1'b0 || S1_ARREADY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_handshakes: got rv=%b rr=%b arr=%b expected 0", S0_RVALID, M_AXI_RREADY, S1_ARREADY);
    end
    tests_run++;
    if (M_AXI_ARVALID !== 1'b0 || M_AXI_ARADDR !== 32'h0 || M_AXI_ARLEN !== 8'd0 || len_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_regs: got v=%b a=%h l=%0d e=%b expected 0", M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN, len_err);
    end
    @(posedge ACLK); #1;
    S1_ARVALID = 1'b0;
    ARESETN    = 1'b1;
    #1;
    tests_run++;
    if (S0_RVALID !== 1'b0 || S1_RVALID !== 1'b0 || M_AXI_RREADY !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_release_beat: got rv=%b%b rr=%b expected 0", S0_RVALID, S1_RVALID, M_AXI_RREADY);
    end
    @(posedge ACLK); #1;
    M_AXI_RVALID = 1'b0;
    S1_ARVALID   = 1'b1;
    grant_and_addr(1, 32'h0000_AA00, 0, 1'b0, 32'h0);
    run_beats(1, 8, 7, -1, 0);
    tests_run++;
    if (len_err !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL fresh_len_err: got %b expected 0", len_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_rready_stall();
    test_len_err();
    test_ar_delay();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_axi_read_arbiter.md
Name: cache_axi_read_arbiter

Overview:
- Shares one AXI4 read-only master port between two read-only cache refill requesters: port 0 is the instruction cache, port 1 is the data cache.
- Each requester uses the same simple AR/R interface the caches already drive: address, valid/ready, data, last.
- Grants one burst at a time with round-robin priority and registers the AXI AR channel.
- Routes R beats back to the granted requester until RLAST, and flags burst-length mismatches.

Parameters:
- M_AXI_ADDR_WIDTH, 32, AXI address width.
- M_AXI_DATA_WIDTH, 32, AXI/requester data width.
- P0_BURST_LEN, 7, ARLEN for port-0 bursts (beats-1).
- P1_BURST_LEN, 7, ARLEN for port-1 bursts (beats-1).
- M_AXI_BURST_SIZE, 2, ARSIZE for both ports.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S0_ARADDR  in  32  port-0 refill address.
- S0_ARVALID  in  1  port-0 request valid.
- S0_ARREADY  out  1  port-0 request accepted.
- S0_RDATA  out  DATA_WIDTH  port-0 read data.
- S0_RRESP  out  2  port-0 read response.
- S0_RVALID  out  1  port-0 beat valid.
- S0_RLAST  out  1  port-0 last beat.
- S0_RREADY  in  1  port-0 beat ready.
- S1_*  (same set as S0_*)  port-1 equivalents.
- M_AXI_ARADDR  out  ADDR_WIDTH  registered read address.
- M_AXI_ARLEN  out  8  registered burst length.
- M_AXI_ARSIZE  out  3  constant M_AXI_BURST_SIZE.
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR).
- M_AXI_ARVALID  out  1  read address valid.
- M_AXI_ARREADY  in  1  read address ready.
- M_AXI_RDATA  in  DATA_WIDTH  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  read last.
- M_AXI_RVALID  in  1  read valid.
- M_AXI_RREADY  out  1  read ready.
- len_err  out  1  sticky error flag; set when RLAST arrives on a beat other than the expected last.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ACLK, ARESETN).
  - While ARESETN=0: state=IDLE, last_grant=1 (so port 0 wins first), M_AXI_ARVALID=0, M_AXI_ARADDR=0, M_AXI_ARLEN=0, beat_cnt=0, len_err=0.
  - While ARESETN=0, all S*_ARREADY, S*_RVALID and M_AXI_RREADY are forced 0.
  - Reset mid-burst abandons the burst; no beats are forwarded after release.
- FSM states: IDLE, ADDR, DATA.
- IDLE (grant):
  - Grant is combinational: if only one SX_ARVALID is set, that port wins.
  - If both are set, the port != last_grant wins.
  - SX_ARREADY=1 only for the winning port, only in IDLE. The other port's ARREADY=0.
  - On that handshake: latch the winner's address into M_AXI_ARADDR and its ARLEN (P0/P1_BURST_LEN) into M_AXI_ARLEN; set owner=winner, last_grant=winner, beat_cnt=0; go to ADDR.
  - M_AXI_ARVALID rises the cycle after acceptance (1-cycle AR latency).
- ADDR:
  - M_AXI_ARVALID=1, with ARADDR and ARLEN held stable.
  - On M_AXI_ARREADY=1: ARVALID falls next cycle; go to DATA.
  - ARREADY may arrive in the first ADDR cycle.
- DATA (combinational routing, no added latency):
  - Owner port: SX_RVALID=M_AXI_RVALID; SX_RDATA, SX_RRESP and SX_RLAST follow M_AXI_*.
  - M_AXI_RREADY=owner SX_RREADY. The non-owner port's RVALID=0.
  - Beat transfer (RVALID&RREADY): beat_cnt+1 (8-bit).
  - RLAST beat with beat_cnt!=latched ARLEN: set len_err.
  - Non-RLAST beat with beat_cnt==ARLEN: set len_err and keep forwarding.
  - RLAST transfer: go to IDLE. A new grant is possible in the next cycle, so there are no back-to-back grants within one cycle.
- Single outstanding transaction; requests arriving in ADDR/DATA wait with ARREADY=0.
- S*_RDATA may carry M_AXI_RDATA to both ports at all times; only RVALID is qualified.
- Requesters must hold ARVALID and ARADDR until ARREADY. A requester that drops ARVALID before grant is ignored.
- RRESP is passed through unmodified; errors are not interpreted.

Test Plan:
- Reset then S0 request addr 0x1FC0_0000, slave ARREADY same cycle, 8 beats D0..D7 with RLAST on the 8th:
  - S0_ARREADY pulses 1 cycle.
  - M_AXI_ARVALID rises the next cycle with ARADDR=0x1FC0_0000, ARLEN=7.
  - S0 receives 8 beats with S0_RLAST on D7; S1_RVALID stays 0; FSM back in IDLE.
- Both ports request in the same cycle (addrs 0x100, 0x200):
  - Port 0 is granted first; after its RLAST, port 1 is granted.
  - Repeat with both valid again: port 0 wins, because last_grant alternates.
- S1 holds RREADY=0 for 3 cycles mid-burst while the slave holds RVALID=1:
  - M_AXI_RREADY=0 for those cycles; no beat is lost or duplicated; beat_cnt is correct.
- Slave asserts RLAST on beat 4 of an ARLEN=7 burst:
  - len_err becomes 1 and stays set; the FSM returns to IDLE.
- Slave delays ARREADY by 5 cycles:
  - ARVALID, ARADDR and ARLEN stay stable for all 5 cycles.
  - A new S0 request during the wait sees S0_ARREADY=0.
- ARESETN pulled low during DATA beat 3, then released:
  - All outputs return to their reset values immediately.
  - After release, a fresh S1 request completes normally.
